// File: rtl/xpb_table_builder_if.sv
// rtl/xpb_table_builder_if.sv - build request, status and digit lookup bundle for xpb_table_builder
interface xpb_table_builder_if #(
    parameter int WIDTH    = 1024,
    parameter int DIG_BITS = 5
);
    logic                start;
    logic [WIDTH-1:0]    base_in;
    logic [WIDTH-1:0]    mod_in;
    logic                busy;
    logic                done;
    logic                err;
    logic [DIG_BITS-1:0] data_in;
    logic [WIDTH-1:0]    data_out;

    modport master (
        output start, base_in, mod_in, data_in,
        input  busy, done, err, data_out
    );

    modport slave (
        input  start, base_in, mod_in, data_in,
        output busy, done, err, data_out
    );
endinterface

// File: rtl/xpb_table_builder.sv
// rtl/xpb_table_builder.sv - runtime builder of e[j] = (j*B) mod M tables with registered digit lookup
// Optional range check on start is enabled by defining XPB_TABLE_RANGE_CHECK_EN.
module xpb_table_builder #(
    parameter int WIDTH    = 1024,
    parameter int DIG_BITS = 5
) (
    input  logic            clk,
    input  logic            rst,
    xpb_table_builder_if.slave bus
);
    localparam int DEPTH = 1 << DIG_BITS;
    localparam logic [DIG_BITS-1:0] LAST_IDX  = '1;
    localparam logic [DIG_BITS-1:0] FIRST_IDX = DIG_BITS'(1);

    typedef enum logic [1:0] {IDLE, ADD, RED, FIN} state_t;

    state_t              state, state_nxt;
    logic                accept;
    logic                range_bad;
    logic [WIDTH-1:0]    base_q;
    logic [WIDTH-1:0]    mod_q;
    logic [WIDTH-1:0]    acc_q;
    logic [WIDTH:0]      sum_q;
    logic [WIDTH:0]      red_r;
    logic [DIG_BITS-1:0] j_q;
    logic [WIDTH-1:0]    table_q [DEPTH];
    logic [WIDTH-1:0]    dout_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

`ifdef XPB_TABLE_RANGE_CHECK_EN
    assign range_bad = (bus.base_in >= bus.mod_in) || (bus.mod_in == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= range_bad;
        end
    end
`else
    assign range_bad = 1'b0;
    assign err_q     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    if (!range_bad) begin
                        state_nxt = ADD;
                    end
                end
            end
            ADD:     state_nxt = RED;
            RED:     state_nxt = (j_q == LAST_IDX) ? FIN : ADD;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // sum carries one extra bit so acc + B never wraps before the conditional subtract
    assign red_r = (sum_q >= {1'b0, mod_q}) ? (sum_q - {1'b0, mod_q}) : sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            mod_q  <= '0;
            acc_q  <= '0;
            sum_q  <= '0;
            j_q    <= '0;
            dout_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            // Read sees the pre-edge table, so an entry written this edge shows up next clock
            dout_q <= table_q[bus.data_in];
            case (state)
                IDLE: begin
                    if (accept && !range_bad) begin
                        base_q     <= bus.base_in;
                        mod_q      <= bus.mod_in;
                        acc_q      <= '0;
                        table_q[0] <= '0;
                        j_q        <= FIRST_IDX;
                        busy_q     <= 1'b1;
                    end
                end
                ADD: begin
                    sum_q <= {1'b0, acc_q} + {1'b0, base_q};
                end
                RED: begin
                    acc_q        <= red_r[WIDTH-1:0];
                    table_q[j_q] <= red_r[WIDTH-1:0];
                    if (j_q != LAST_IDX) begin
                        j_q <= j_q + FIRST_IDX;
                    end
                end
                FIN: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.data_out = dout_q;
endmodule
